// File: rtl/bnn_weight_streamer.sv
// Serializes 8-bit neuron weight bytes into low/high nibble beats for the BNN core's
// weight-load pins, tracking the core's slot counter so the host knows which neuron is loaded.
module bnn_weight_streamer #(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       wt_nibble,
  output logic             wt_load_en,
  output logic [IDX_W-1:0] neuron_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);

  state_e     state_q;
  logic [7:0] hold_q;
  logic       accept;

  // in_ready is registered, so it already reflects the current state.
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_q     <= 8'h00;
      neuron_idx <= '0;
      wt_nibble  <= 4'h0;
      wt_load_en <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (accept) begin
            state_q    <= StLo;
            hold_q     <= in_data;
            wt_nibble  <= in_data[3:0];
            wt_load_en <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StLo: begin
          // The high beat always follows so the core's half-select never desyncs.
          state_q    <= StHi;
          wt_nibble  <= hold_q[7:4];
          wt_load_en <= 1'b1;
          in_ready   <= 1'b1;
          busy       <= 1'b1;
          done       <= (neuron_idx == LastIdx);
        end
        StHi: begin
          neuron_idx <= neuron_idx + 1'b1;
          done       <= 1'b0;
          if (accept) begin
            state_q    <= StLo;
            hold_q     <= in_data;
            wt_nibble  <= in_data[3:0];
            wt_load_en <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
          end else begin
            state_q    <= StIdle;
            wt_nibble  <= 4'h0;
            wt_load_en <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          wt_nibble  <= 4'h0;
          wt_load_en <= 1'b0;
          in_ready   <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Bench for bnn_weight_streamer: byte scoreboard plus a model of the core's half-select
// and slot counter, fed from a negedge monitor.
module tb_bnn_weight_streamer;

  localparam int NumNeurons = 8;
  localparam int IdxW       = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      wt_nibble;
  logic            wt_load_en;
  logic [IdxW-1:0] neuron_idx;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  int         half = 0;
  int         slot = 0;
  int         run_len = 0;
  int         max_run = 0;
  int         done_cnt = 0;
  logic [3:0] lo_nib = 4'h0;

  bnn_weight_streamer #(
    .NUM_NEURONS(NumNeurons),
    .IDX_W      (IdxW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wt_nibble (wt_nibble),
    .wt_load_en(wt_load_en),
    .neuron_idx(neuron_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Core model: half-select toggles on each enabled beat, slot advances after the high beat.
  always @(negedge clk) begin
    logic [8:0] exp_byte;
    if (!rst_n) begin
      half    = 0;
      slot    = 0;
      run_len = 0;
    end else if (wt_load_en) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      check_eq("beat_busy", busy, 1);
      if (half == 0) begin
        lo_nib = wt_nibble;
        check_eq("lo_ready", in_ready, 0);
        check_eq("lo_done", done, 0);
        half = 1;
      end else begin
        check_eq("hi_slot", neuron_idx, slot);
        check_eq("hi_done", done, (slot == NumNeurons - 1));
        check_eq("hi_ready", in_ready, 1);
        exp_byte = (sb_q.size() > 0) ? {1'b0, sb_q.pop_front()} : 9'h100;
        check_eq("sb_byte", {wt_nibble, lo_nib}, exp_byte);
        if (done) done_cnt++;
        half = 0;
        slot = (slot + 1) % NumNeurons;
      end
    end else begin
      if (half != 0) check_eq("pair_split", wt_load_en, 1);
      run_len = 0;
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_nibble", wt_nibble, 0);
    end
  end

  // Returns #1 after the accepting edge with in_valid still high.
  task automatic send_byte(input logic [7:0] b);
    logic ready_seen;
    ready_seen = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 20; n++) begin
      ready_seen = in_ready;
      @(posedge clk);
      if (ready_seen) break;
    end
    check_eq("accept", ready_seen, 1);
    if (ready_seen) sb_q.push_back(b);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_idx", neuron_idx, 0);
    check_eq("rst_load_en", wt_load_en, 0);
    check_eq("rst_busy", busy, 0);

    // Reset mid-byte, asserted during the low beat.
    send_byte(8'h3C);
    idle_cycles(3);
    check_eq("pre_rst_idx", neuron_idx, 1);
    send_byte(8'h77);
    in_valid = 1'b0;
    check_eq("pre_rst_lo", wt_load_en, 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("async_load_en", wt_load_en, 0);
    check_eq("async_nibble", wt_nibble, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_idx", neuron_idx, 0);
    check_eq("async_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("post_rst_ready", in_ready, 1);
    check_eq("post_rst_idx", neuron_idx, 0);

    // Single byte timeline.
    send_byte(8'hA5);
    in_valid = 1'b0;
    in_data  = 8'hFF;
    check_eq("t1_nibble", wt_nibble, 4'h5);
    check_eq("t1_load_en", wt_load_en, 1);
    check_eq("t1_ready", in_ready, 0);
    check_eq("t1_idx", neuron_idx, 0);
    @(posedge clk);
    #1;
    check_eq("t2_nibble", wt_nibble, 4'hA);
    check_eq("t2_load_en", wt_load_en, 1);
    check_eq("t2_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("t3_load_en", wt_load_en, 0);
    check_eq("t3_idx", neuron_idx, 1);
    check_eq("t3_busy", busy, 0);

    // Full set streamed back to back.
    do_reset();
    max_run  = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: send_byte(8'hF0);
        1: send_byte(8'h0F);
        2: send_byte(8'h3C);
        default: send_byte(8'hC3);
      endcase
    end
    idle_cycles(4);
    check_eq("stream_run", max_run, 16);
    check_eq("stream_done", done_cnt, 1);
    check_eq("stream_idx", neuron_idx, 0);
    check_eq("stream_sb_empty", sb_q.size(), 0);

    // Random gaps over 20 bytes.
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        idle_cycles($urandom_range(1, 3));
      end
    end
    idle_cycles(4);
    check_eq("rand_done", done_cnt, 2);
    check_eq("rand_idx", neuron_idx, 4);
    check_eq("rand_sb_empty", sb_q.size(), 0);

    // Nine bytes: slot wraps onto 0.
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < 9; i++) send_byte(8'(i * 17 + 3));
    idle_cycles(4);
    check_eq("wrap_done", done_cnt, 1);
    check_eq("wrap_idx", neuron_idx, 1);
    check_eq("wrap_model_slot", slot, 1);
    check_eq("wrap_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_weight_streamer.md
# bnn_weight_streamer

Host-side transmitter for the BNN weight-load nibble interface. It accepts whole 8-bit neuron weight bytes over a valid/ready handshake and serializes each byte into two consecutive nibble beats with the load enable asserted: low nibble first, then high nibble. It tracks which neuron slot (0..NUM_NEURONS-1) each byte targets and flags completion of a full weight set. Its outputs drive the BNN core's bidirectional pins: nibble to uio[7:4], load enable to uio[3].

## Interface
- NUM_NEURONS, 8, number of neuron weight slots per full load (power of two)
- IDX_W, 3, width of neuron index, log2(NUM_NEURONS)
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset (shared with BNN core)
- in_data  input  8  weight byte; bit i pairs with BNN input bit i
- in_valid  input  1  in_data valid
- in_ready  output  1  streamer can accept a byte this cycle
- wt_nibble  output  4  nibble beat to core (uio[7:4])
- wt_load_en  output  1  load enable beat (uio[3])
- neuron_idx  output  IDX_W  slot of the byte currently or next transmitted
- busy  output  1  a byte is being transmitted
- done  output  1  one-cycle pulse on final beat of slot NUM_NEURONS-1

## Operation
- States: IDLE, LO, HI. All outputs registered.
- IDLE: wt_load_en=0, wt_nibble=0, in_ready=1. On in_valid & in_ready, capture in_data into hold register and go to LO.
- LO: wt_nibble=hold[3:0], wt_load_en=1, in_ready=0. Always go to HI next.
- HI: wt_nibble=hold[7:4], wt_load_en=1, in_ready=1. At end of cycle neuron_idx increments (wraps NUM_NEURONS-1 -> 0). If in_valid was accepted this cycle, go to LO with the new byte, otherwise go to IDLE.
- Beats are never split: once LO is entered, HI follows unconditionally. The core's half-select toggles only on enabled beats, so an odd count would desynchronize it permanently.
- busy = (state != IDLE).
- done = 1 during the HI cycle when neuron_idx == NUM_NEURONS-1; 0 otherwise.
- neuron_idx mirrors the core's slot counter. There is no clear other than reset, because the core's counter has none.
- in_data is ignored when not accepted; no buffering beyond the hold register.

## Timing
- Reset (async assert): state=IDLE, hold=0, neuron_idx=0, wt_nibble=0, wt_load_en=0, busy=0, done=0, in_ready=1 after deassert. Reset mid-byte drops the byte. The core is reset by the same rst_n, so both ends resync.
- Byte accepted at edge t:
  - cycle t+1: LO beat.
  - cycle t+2: HI beat.
  - Latency 1 cycle to first beat.
- Back-to-back: byte accepted during HI (edge t+2) gives its LO at t+3. Sustained throughput is 1 byte per 2 cycles, with wt_load_en continuously high.
- Stall: in_valid low during HI gives IDLE next cycle with wt_load_en=0. Gaps occur only between complete pairs.
- in_ready is low only in LO.
- done coincides with the last HI beat. With continuous streaming the next byte goes to slot 0 with no bubble.

## Test plan
- Reset: hold rst_n=0 mid-stream (during LO) -> outputs 0 immediately without clock. After release: in_ready=1, neuron_idx=0, and the next byte starts at slot 0.
- Single byte 0xA5 accepted at edge t:
  - cycle t+1: nibble=0x5, load_en=1.
  - cycle t+2: nibble=0xA, load_en=1, in_ready=1.
  - cycle t+3: load_en=0, neuron_idx=1, busy=0.
- Eight bytes 0xF0,0x0F,0x3C,0xC3,0xF0,0x0F,0x3C,0xC3 with in_valid held high:
  - 16 contiguous load_en cycles, nibbles 0,F,F,0,C,3,3,C,...
  - done high only on beat 16; neuron_idx returns to 0.
- Random in_valid gaps over 20 bytes -> load_en-high cycles always come in adjacent pairs. Scoreboard reassembles {hi,lo} and matches the input byte sequence. done fires after bytes 8 and 16.
- Protocol checker modelling the core's half-select/slot counter over 9 bytes -> checker slot index equals neuron_idx at every HI beat, and slot wraps 7 -> 0 on the ninth byte.
